l1d_multi_req_arbiter: RTL and testbench

L1D_MULTI_REQ_ARBITER -- requirements
Module: l1d_multi_req_arbiter

---
 rtl/l1d_package.sv | 27 ++
 rtl/l1d_multi_req_arbiter_if.sv | 40 ++++
 rtl/l1d_rr_pick.sv | 29 ++
 rtl/l1d_multi_req_arbiter.sv | 112 +++++++++++
 tb/tb_l1d_multi_req_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/l1d_package.sv
// rtl/l1d_package.sv - shared L1D request payload type, MSHR id width and arbiter limits
package l1d_package;

  localparam int L1D_MSHR_ID_WIDTH = 4;
  localparam int L1D_ARB_MAX_CH    = 8;
  localparam int L1D_ADDR_WIDTH    = 32;
  localparam int L1D_TID_WIDTH     = 6;

  typedef enum logic [1:0] {
    L1D_OP_LOAD     = 2'd0,
    L1D_OP_STORE    = 2'd1,
    L1D_OP_PREFETCH = 2'd2,
    L1D_OP_ATOMIC   = 2'd3
  } l1d_op_e;

  typedef struct packed {
    l1d_op_e                   op;
    logic [L1D_ADDR_WIDTH-1:0] addr;
    logic [L1D_TID_WIDTH-1:0]  tid;
  } pack_l1d_req;

  // Source field encodes demand channels 0..num_ch-1 plus one extra code for prefetch.
  function automatic int l1d_arb_src_width(input int num_ch);
    return $clog2(num_ch + 1);
  endfunction

endpackage

// File: rtl/l1d_multi_req_arbiter_if.sv
// rtl/l1d_multi_req_arbiter_if.sv - demand/prefetch/credit inputs and tag-pipe output of the L1D arbiter
interface l1d_multi_req_arbiter_if
  import l1d_package::*;
#(
  parameter int NUM_CH = 4
);

  localparam int SRC_W = l1d_arb_src_width(NUM_CH);

  logic [NUM_CH-1:0]            req_vld;
  logic [NUM_CH-1:0]            req_rdy;
  pack_l1d_req [NUM_CH-1:0]     req_pld;

  logic                         prefetch_vld;
  logic                         prefetch_rdy;
  pack_l1d_req                  prefetch_pld;

  logic                         alloc_vld;
  logic                         alloc_rdy;
  logic [L1D_MSHR_ID_WIDTH-1:0] alloc_index;

  logic                         tag_pipe_req_vld;
  logic                         tag_pipe_req_rdy;
  pack_l1d_req                  tag_pipe_req_pld;
  logic [L1D_MSHR_ID_WIDTH-1:0] tag_pipe_req_index;
  logic [SRC_W-1:0]             tag_pipe_req_src;

  modport master (
    output req_vld, req_pld, prefetch_vld, prefetch_pld, alloc_vld, alloc_index, tag_pipe_req_rdy,
    input  req_rdy, prefetch_rdy, alloc_rdy,
    input  tag_pipe_req_vld, tag_pipe_req_pld, tag_pipe_req_index, tag_pipe_req_src
  );

  modport slave (
    input  req_vld, req_pld, prefetch_vld, prefetch_pld, alloc_vld, alloc_index, tag_pipe_req_rdy,
    output req_rdy, prefetch_rdy, alloc_rdy,
    output tag_pipe_req_vld, tag_pipe_req_pld, tag_pipe_req_index, tag_pipe_req_src
  );

endinterface

// File: rtl/l1d_rr_pick.sv
// rtl/l1d_rr_pick.sv - one-hot picker: round-robin from a start pointer, or fixed lowest-index priority
module l1d_rr_pick #(
  parameter int N     = 4,
  parameter bit RR_EN = 1'b1
) (
  input  logic [N-1:0]         i_vld,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_gnt
);

  localparam int PW = $clog2(N);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_hi;
  logic [N-1:0] w_sel;

  always_comb begin
    w_mask = '0;
    for (int j = 0; j < N; j++) begin
      w_mask[j] = (PW'(j) >= i_ptr);
    end
  end

  // Requests at or above the pointer go first; otherwise the search has wrapped to the bottom.
  assign w_hi  = i_vld & w_mask;
  assign w_sel = (RR_EN && (|w_hi)) ? w_hi : i_vld;
  assign o_gnt = w_sel & (~w_sel + N'(1));

endmodule

// File: rtl/l1d_multi_req_arbiter.sv
// rtl/l1d_multi_req_arbiter.sv - arbitrates demand channels and prefetch for MSHR credits into a registered tag-pipe request
module l1d_multi_req_arbiter
  import l1d_package::*;
#(
  parameter int NUM_CH       = 4,
  parameter bit RR_EN        = 1'b1,
  parameter int PF_STARVE_TH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  l1d_multi_req_arbiter_if.slave bus
);

  localparam int               PW     = $clog2(NUM_CH);
  localparam int               SRC_W  = l1d_arb_src_width(NUM_CH);
  localparam logic [7:0]       PF_TH  = 8'(PF_STARVE_TH);
  localparam logic [SRC_W-1:0] PF_SRC = SRC_W'(NUM_CH);

  logic                         r_vld;
  logic [SRC_W-1:0]             r_src;
  pack_l1d_req                  r_pld;
  logic [L1D_MSHR_ID_WIDTH-1:0] r_index;
  logic [PW-1:0]                r_rr_ptr;
  logic [7:0]                   r_pf_cnt;

  logic                         w_load;
  logic                         w_dem_any;
  logic                         w_promoted;
  logic                         w_grant;
  logic                         w_pf_win;
  logic                         w_dem_win;
  logic [NUM_CH-1:0]            w_dem_gnt;
  logic [PW-1:0]                w_dem_idx;
  pack_l1d_req                  w_dem_pld;

  l1d_rr_pick #(
    .N     (NUM_CH),
    .RR_EN (RR_EN)
  ) u_pick (
    .i_vld (bus.req_vld),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_dem_gnt)
  );

  assign w_load     = ~r_vld | bus.tag_pipe_req_rdy;
  assign w_dem_any  = |bus.req_vld;
  assign w_promoted = (r_pf_cnt == PF_TH);
  // Gating with rst keeps every ready low while reset is held, even though state resets asynchronously.
  assign w_grant    = ~rst & w_load & bus.alloc_vld & (w_dem_any | bus.prefetch_vld);
  assign w_pf_win   = bus.prefetch_vld & (w_promoted | ~w_dem_any);
  assign w_dem_win  = w_grant & ~w_pf_win;

  always_comb begin
    w_dem_idx = '0;
    w_dem_pld = bus.req_pld[0];
    for (int j = 0; j < NUM_CH; j++) begin
      if (w_dem_gnt[j]) begin
        w_dem_idx = PW'(j);
        w_dem_pld = bus.req_pld[j];
      end
    end
  end

  assign bus.req_rdy            = w_dem_win ? w_dem_gnt : '0;
  assign bus.prefetch_rdy       = w_grant & w_pf_win;
  assign bus.alloc_rdy          = w_grant;
  assign bus.tag_pipe_req_vld   = r_vld;
  assign bus.tag_pipe_req_src   = r_src;
  assign bus.tag_pipe_req_pld   = r_pld;
  assign bus.tag_pipe_req_index = r_index;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_src <= '0;
    end else if (w_load) begin
      r_vld <= w_grant;
      if (w_grant) begin
        r_src <= w_pf_win ? PF_SRC : SRC_W'(w_dem_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_pld   <= w_pf_win ? bus.prefetch_pld : w_dem_pld;
      r_index <= bus.alloc_index;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (RR_EN && w_dem_win) begin
      r_rr_ptr <= (w_dem_idx == PW'(NUM_CH - 1)) ? '0 : w_dem_idx + PW'(1);
    end
  end

  // A credit stall freezes the starvation count; otherwise a vanished prefetch forgets its history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pf_cnt <= '0;
    end else if (bus.alloc_vld) begin
      if (!bus.prefetch_vld || (w_grant && w_pf_win)) begin
        r_pf_cnt <= '0;
      end else if (w_dem_win && !w_promoted) begin
        r_pf_cnt <= r_pf_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_l1d_multi_req_arbiter.sv
// tb/tb_l1d_multi_req_arbiter.sv - table vectors plus random stimulus against a reference model, two arbiter configurations
module tb_l1d_multi_req_arbiter;
  import l1d_package::*;

  localparam int NCH   = 4;
  localparam int PF_CH = NCH;

  typedef struct {
    bit         rst;
    logic [3:0] rv;
    bit         pv;
    bit         av;
    logic [3:0] ai;
    bit         tr;
    logic [3:0] e_rdy_a;
    bit         e_pfr_a;
    bit         e_vld_a;
    logic [2:0] e_src_a;
    logic [3:0] e_idx_a;
    logic [3:0] e_rdy_b;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                s_rst;
  logic [3:0]          s_req_vld;
  pack_l1d_req [3:0]   s_req_pld;
  logic                s_pf_vld;
  pack_l1d_req         s_pf_pld;
  logic                s_alloc_vld;
  logic [3:0]          s_alloc_idx;
  logic                s_tp_rdy;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  bit          m_vld [2];
  int          m_src [2];
  logic [3:0]  m_idx [2];
  pack_l1d_req m_pld [2];
  int          m_ptr [2];
  int          m_cnt [2];

  vec_t vq[$];

  l1d_multi_req_arbiter_if #(.NUM_CH(NCH)) ifa ();
  l1d_multi_req_arbiter_if #(.NUM_CH(NCH)) ifb ();

  l1d_multi_req_arbiter #(.NUM_CH(NCH), .RR_EN(1'b1), .PF_STARVE_TH(3)) dut_a (
    .clk (clk), .rst (s_rst), .bus (ifa.slave)
  );
  l1d_multi_req_arbiter #(.NUM_CH(NCH), .RR_EN(1'b0), .PF_STARVE_TH(8)) dut_b (
    .clk (clk), .rst (s_rst), .bus (ifb.slave)
  );

  assign ifa.req_vld = s_req_vld;     assign ifb.req_vld = s_req_vld;
  assign ifa.req_pld = s_req_pld;     assign ifb.req_pld = s_req_pld;
  assign ifa.prefetch_vld = s_pf_vld; assign ifb.prefetch_vld = s_pf_vld;
  assign ifa.prefetch_pld = s_pf_pld; assign ifb.prefetch_pld = s_pf_pld;
  assign ifa.alloc_vld = s_alloc_vld; assign ifb.alloc_vld = s_alloc_vld;
  assign ifa.alloc_index = s_alloc_idx; assign ifb.alloc_index = s_alloc_idx;
  assign ifa.tag_pipe_req_rdy = s_tp_rdy; assign ifb.tag_pipe_req_rdy = s_tp_rdy;

  logic [3:0]  d_req_rdy [2];
  logic        d_pf_rdy [2];
  logic        d_alloc_rdy [2];
  logic        d_vld [2];
  logic [2:0]  d_src [2];
  logic [3:0]  d_idx [2];
  pack_l1d_req d_pld [2];

  assign d_req_rdy[0] = ifa.req_rdy;          assign d_req_rdy[1] = ifb.req_rdy;
  assign d_pf_rdy[0] = ifa.prefetch_rdy;      assign d_pf_rdy[1] = ifb.prefetch_rdy;
  assign d_alloc_rdy[0] = ifa.alloc_rdy;      assign d_alloc_rdy[1] = ifb.alloc_rdy;
  assign d_vld[0] = ifa.tag_pipe_req_vld;     assign d_vld[1] = ifb.tag_pipe_req_vld;
  assign d_src[0] = ifa.tag_pipe_req_src;     assign d_src[1] = ifb.tag_pipe_req_src;
  assign d_idx[0] = ifa.tag_pipe_req_index;   assign d_idx[1] = ifb.tag_pipe_req_index;
  assign d_pld[0] = ifa.tag_pipe_req_pld;     assign d_pld[1] = ifb.tag_pipe_req_pld;

  function automatic int cfg_th(input int c);
    return (c == 0) ? 3 : 8;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Config 0 is round-robin, config 1 is fixed priority; winner chosen by scanning channels in order.
  task automatic model_step(input int c);
    int         win;
    int         ch;
    bit         load;
    bit         grant;
    logic [3:0] exp_rdy;
    string      t;
    t = $sformatf("cyc%0d cfg%0d", cyc, c);
    if (s_rst) begin
      m_vld[c] = 1'b0; m_src[c] = 0; m_ptr[c] = 0; m_cnt[c] = 0;
    end
    load  = !m_vld[c] || s_tp_rdy;
    grant = !s_rst && load && s_alloc_vld && (s_req_vld != 4'd0 || s_pf_vld);
    win   = -1;
    if (grant) begin
      if (s_pf_vld && (m_cnt[c] == cfg_th(c) || s_req_vld == 4'd0)) begin
        win = PF_CH;
      end else begin
        for (int k = 0; k < NCH; k++) begin
          ch = (c == 0) ? (m_ptr[c] + k) % NCH : k;
          if (win < 0 && s_req_vld[2'(ch)]) win = ch;
        end
      end
    end
    exp_rdy = (win >= 0 && win < PF_CH) ? 4'(1 << win) : 4'd0;
    chk({t, " req_rdy"},   64'(d_req_rdy[c]),   64'(exp_rdy));
    chk({t, " pf_rdy"},    64'(d_pf_rdy[c]),    64'(win == PF_CH));
    chk({t, " alloc_rdy"}, 64'(d_alloc_rdy[c]), 64'(grant));
    chk({t, " out_vld"},   64'(d_vld[c]),       64'(m_vld[c]));
    chk({t, " out_src"},   64'(d_src[c]),       64'(m_src[c]));
    if (m_vld[c]) begin
      chk({t, " out_index"}, 64'(d_idx[c]), 64'(m_idx[c]));
      chk({t, " out_pld"},   64'(d_pld[c]), 64'(m_pld[c]));
    end
    if (!s_rst) begin
      if (s_alloc_vld) begin
        if (!s_pf_vld || win == PF_CH) m_cnt[c] = 0;
        else if (win >= 0 && m_cnt[c] < cfg_th(c)) m_cnt[c] = m_cnt[c] + 1;
      end
      if (win >= 0 && win < PF_CH) m_ptr[c] = (win + 1) % NCH;
      if (load) begin
        m_vld[c] = grant;
        if (grant) begin
          m_src[c] = win;
          m_idx[c] = s_alloc_idx;
          m_pld[c] = (win == PF_CH) ? s_pf_pld : s_req_pld[2'(win)];
        end
      end
    end
  endtask

  task automatic step();
    #1;
    model_step(0);
    model_step(1);
    cyc++;
  endtask

  task automatic addv(input bit rst, input logic [3:0] rv, input bit pv, input bit av, input logic [3:0] ai,
                      input bit tr, input logic [3:0] ea, input bit ep, input bit ev, input logic [2:0] es,
                      input logic [3:0] ei, input logic [3:0] eb);
    vq.push_back('{rst, rv, pv, av, ai, tr, ea, ep, ev, es, ei, eb});
  endtask

  initial begin
    s_rst = 1'b1; s_req_vld = '0; s_pf_vld = 1'b0; s_alloc_vld = 1'b0; s_alloc_idx = '0; s_tp_rdy = 1'b1;
    for (int j = 0; j < NCH; j++) s_req_pld[j] = '{L1D_OP_LOAD, 32'h1000_0000 + 32'(j), 6'(j)};
    s_pf_pld = '{L1D_OP_PREFETCH, 32'hF000_0000, 6'h3F};

    //   rst rv     pv av ai     tr | rdy_a pfr vld src idx   rdy_b
    addv(1, 4'hF, 0, 1, 4'd3, 1, 4'h0, 0, 0, 3'd0, 4'd0, 4'h0);
    addv(0, 4'hF, 0, 1, 4'd3, 1, 4'h1, 0, 0, 3'd0, 4'd0, 4'h1);
    addv(0, 4'hF, 0, 1, 4'd3, 1, 4'h2, 0, 1, 3'd0, 4'd3, 4'h1);
    addv(0, 4'hF, 0, 1, 4'd3, 1, 4'h4, 0, 1, 3'd1, 4'd3, 4'h1);
    addv(0, 4'hF, 0, 1, 4'd3, 1, 4'h8, 0, 1, 3'd2, 4'd3, 4'h1);
    addv(0, 4'hF, 0, 1, 4'd3, 1, 4'h1, 0, 1, 3'd3, 4'd3, 4'h1);
    addv(0, 4'hF, 0, 1, 4'd3, 1, 4'h2, 0, 1, 3'd0, 4'd3, 4'h1);
    addv(0, 4'hF, 0, 1, 4'd3, 1, 4'h4, 0, 1, 3'd1, 4'd3, 4'h1);
    addv(0, 4'hF, 0, 1, 4'd3, 1, 4'h8, 0, 1, 3'd2, 4'd3, 4'h1);
    for (int k = 0; k < 5; k++) addv(0, 4'hF, 0, 1, 4'd3, 0, 4'h0, 0, 1, 3'd3, 4'd3, 4'h0);
    addv(0, 4'hF, 0, 1, 4'd3, 1, 4'h1, 0, 1, 3'd3, 4'd3, 4'h1);
    addv(0, 4'hF, 0, 0, 4'd3, 1, 4'h0, 0, 1, 3'd0, 4'd3, 4'h0);
    addv(0, 4'hF, 0, 0, 4'd3, 1, 4'h0, 0, 0, 3'd0, 4'd3, 4'h0);
    addv(0, 4'hF, 0, 1, 4'd5, 1, 4'h2, 0, 0, 3'd0, 4'd0, 4'h1);
    addv(0, 4'hF, 0, 0, 4'd3, 1, 4'h0, 0, 1, 3'd1, 4'd5, 4'h0);
    addv(0, 4'h6, 0, 1, 4'd3, 1, 4'h4, 0, 0, 3'd1, 4'd0, 4'h2);
    addv(0, 4'h6, 0, 1, 4'd3, 1, 4'h2, 0, 1, 3'd2, 4'd3, 4'h2);
    addv(0, 4'h6, 0, 1, 4'd3, 1, 4'h4, 0, 1, 3'd1, 4'd3, 4'h2);
    addv(0, 4'h6, 0, 1, 4'd3, 0, 4'h0, 0, 1, 3'd2, 4'd3, 4'h0);
    addv(1, 4'h6, 0, 1, 4'd3, 0, 4'h0, 0, 0, 3'd0, 4'd0, 4'h0);
    addv(0, 4'hF, 0, 1, 4'd3, 1, 4'h1, 0, 0, 3'd0, 4'd0, 4'h1);
    addv(0, 4'h1, 1, 1, 4'd3, 1, 4'h1, 0, 1, 3'd0, 4'd3, 4'h1);
    addv(0, 4'h1, 1, 1, 4'd3, 1, 4'h1, 0, 1, 3'd0, 4'd3, 4'h1);
    addv(0, 4'h1, 1, 1, 4'd3, 1, 4'h1, 0, 1, 3'd0, 4'd3, 4'h1);
    addv(0, 4'h1, 1, 1, 4'd3, 1, 4'h0, 1, 1, 3'd0, 4'd3, 4'h1);
    addv(0, 4'h1, 1, 1, 4'd3, 1, 4'h1, 0, 1, 3'd4, 4'd3, 4'h1);
    addv(0, 4'h0, 0, 1, 4'd3, 1, 4'h0, 0, 1, 3'd0, 4'd3, 4'h0);
    addv(0, 4'h0, 0, 1, 4'd3, 1, 4'h0, 0, 0, 3'd0, 4'd3, 4'h0);
    addv(0, 4'h0, 1, 1, 4'd3, 1, 4'h0, 1, 0, 3'd0, 4'd3, 4'h0);
    addv(0, 4'h0, 0, 1, 4'd3, 1, 4'h0, 0, 1, 3'd4, 4'd3, 4'h0);

    @(negedge clk);
    foreach (vq[i]) begin
      s_rst = vq[i].rst; s_req_vld = vq[i].rv; s_pf_vld = vq[i].pv;
      s_alloc_vld = vq[i].av; s_alloc_idx = vq[i].ai; s_tp_rdy = vq[i].tr;
      step();
      chk($sformatf("tbl%0d req_rdy_a", i), 64'(ifa.req_rdy), 64'(vq[i].e_rdy_a));
      chk($sformatf("tbl%0d pf_rdy_a", i), 64'(ifa.prefetch_rdy), 64'(vq[i].e_pfr_a));
      chk($sformatf("tbl%0d out_vld_a", i), 64'(ifa.tag_pipe_req_vld), 64'(vq[i].e_vld_a));
      chk($sformatf("tbl%0d out_src_a", i), 64'(ifa.tag_pipe_req_src), 64'(vq[i].e_src_a));
      if (vq[i].e_vld_a) chk($sformatf("tbl%0d out_index_a", i), 64'(ifa.tag_pipe_req_index), 64'(vq[i].e_idx_a));
      chk($sformatf("tbl%0d req_rdy_b", i), 64'(ifb.req_rdy), 64'(vq[i].e_rdy_b));
      @(negedge clk);
    end

    for (int i = 0; i < 3000; i++) begin
      s_rst       = ($urandom_range(0, 199) == 0);
      s_req_vld   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      s_pf_vld    = ($urandom_range(0, 7) == 0) ? ~s_pf_vld : s_pf_vld;
      s_alloc_vld = ($urandom_range(0, 4) != 0);
      s_alloc_idx = 4'($urandom);
      s_tp_rdy    = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < NCH; j++) s_req_pld[j] = '{l1d_op_e'($urandom_range(0, 3)), 32'($urandom), 6'($urandom)};
      s_pf_pld = '{L1D_OP_PREFETCH, 32'($urandom), 6'($urandom)};
      step();
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
